// File: rtl/sod_pkg.sv
// Shared sudoku game types: cell and board encodings, the board-checker state
// set, and the row/col to flat cell index mapping.
package sod_pkg;

  typedef logic [1:0] cell_t;
  typedef cell_t [3:0][3:0] board_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } sod_state_e;

  localparam logic [15:0] FULL_MASK = 16'hFFFF;

  // Flat cell index used by GIVEN_MASK and the filled vector: row*4+col.
  function automatic logic [3:0] cellIndex(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/sod_board_check.sv
// Player board tracker: preloads givens from the answer key on each game
// start, checks placements against the key, counts mistakes, decides win/lose.
module sod_board_check
  import sod_pkg::*;
#(
  parameter logic [15:0] GIVEN_MASK   = 16'b1001_0110_0110_1001,
  parameter int unsigned MAX_MISTAKES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        newGame,
  input  board_t      cardArray,
  input  logic        place,
  input  logic [1:0]  row,
  input  logic [1:0]  col,
  input  cell_t       value,
  output board_t      board,
  output logic [15:0] filled,
  output logic [1:0]  mistakes,
  output logic        wrong,
  output logic        win,
  output logic        lose
);

  localparam logic [1:0] MAX_M = 2'(MAX_MISTAKES);

  sod_state_e  state;
  logic [3:0]  idx;
  logic [15:0] filledNext;
  logic [1:0]  mistakesNext;
  logic        isOpen;
  logic        isMatch;

  assign idx          = cellIndex(row, col);
  assign filledNext   = filled | (16'b1 << idx);
  assign isOpen       = place && !filled[idx];
  assign isMatch      = (value == cardArray[row][col]);
  // Saturate rather than wrap, even though PLAY leaves before reaching the cap.
  assign mistakesNext = (mistakes == MAX_M) ? mistakes : mistakes + 2'd1;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values; the board is a 32-bit register bank,
  // not a RAM, so clearing it on reset is legitimate.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_LOAD;
      board    <= '0;
      filled   <= '0;
      mistakes <= '0;
      wrong    <= 1'b0;
    end else begin
      wrong <= 1'b0;
      if (newGame) begin
        // The key selector advances on this same edge; LOAD picks up the new key.
        state    <= ST_LOAD;
        board    <= '0;
        filled   <= '0;
        mistakes <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            for (int r = 0; r < 4; r++) begin
              for (int c = 0; c < 4; c++) begin
                board[r][c] <= GIVEN_MASK[cellIndex(2'(r), 2'(c))] ? cardArray[r][c] : '0;
              end
            end
            filled   <= GIVEN_MASK;
            mistakes <= '0;
            state    <= ST_PLAY;
          end
          ST_PLAY: begin
            if (isOpen) begin
              if (isMatch) begin
                board[row][col] <= value;
                filled          <= filledNext;
                if (filledNext == FULL_MASK) state <= ST_WIN;
              end else begin
                mistakes <= mistakesNext;
                wrong    <= 1'b1;
                if (mistakesNext == MAX_M) state <= ST_LOSE;
              end
            end
          end
          default: ; // WIN and LOSE are terminal until newGame or reset
        endcase
      end
    end
  end

  assign win  = (state == ST_WIN);
  assign lose = (state == ST_LOSE);

endmodule

// File: tb/tb_sod_board_check.sv
// Randomized scoreboard bench for sod_board_check with an array-based game model
// and a local stand-in for the answer-key selector.
module tb_sod_board_check;
  import sod_pkg::*;

  localparam bit [15:0] GIVEN = 16'h9669;
  localparam int        MAXM  = 3;
  localparam int P_LOAD = 0, P_PLAY = 1, P_WON = 2, P_LOST = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        newGame = 1'b0;
  logic        place = 1'b0;
  logic [1:0]  row = '0, col = '0;
  cell_t       value = '0;
  board_t      cardArray, board;
  logic [15:0] filled;
  logic [1:0]  mistakes;
  logic        wrong, win, lose;

  sod_board_check #(.GIVEN_MASK(GIVEN), .MAX_MISTAKES(MAXM)) dut (
    .clk(clk), .reset(reset), .newGame(newGame), .cardArray(cardArray),
    .place(place), .row(row), .col(col), .value(value),
    .board(board), .filled(filled), .mistakes(mistakes),
    .wrong(wrong), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // Answer keys: game 0 and game 1 as given, games 2/3 are symbol relabelings.
  int k0[16] = '{0,3,2,1, 2,1,0,3, 1,2,3,0, 3,0,1,2};
  int k1[16] = '{1,3,0,2, 0,2,3,1, 2,0,1,3, 3,1,2,0};

  function automatic int keyCell(input int g, input int r, input int c);
    int v;
    v = (g % 2 == 0) ? k0[r*4+c] : k1[r*4+c];
    if ((g % 4) >= 2) v = v ^ 3;
    return v;
  endfunction

  // Answer-key selector stand-in: advances on the newGame edge, game 0 on reset.
  int gameIdx = 0;
  always @(posedge clk) begin
    if (reset) gameIdx <= 0;
    else if (newGame) gameIdx <= gameIdx + 1;
  end
  always_comb begin
    cardArray = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        cardArray[r][c] = 2'(keyCell(gameIdx, r, c));
  end

  // Behavioural game model.
  int mBoard[16];
  bit mFilled[16];
  int mMistakes = 0;
  bit mWrong = 0;
  int mPhase = P_LOAD;
  int mGame = 0;

  typedef struct {
    board_t      board;
    logic [15:0] filled;
    logic [1:0]  mistakes;
    logic        wrong, win, lose;
  } snap_t;
  snap_t expQ[$];

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearGame();
    for (int i = 0; i < 16; i++) begin
      mBoard[i] = 0;
      mFilled[i] = 0;
    end
    mMistakes = 0;
  endtask

  task automatic modelStep(input bit rst, input bit ng, input bit pl,
                           input int r, input int c, input int v);
    int nFilled;
    mWrong = 0;
    if (rst) begin
      clearGame(); mPhase = P_LOAD; mGame = 0;
    end else if (ng) begin
      clearGame(); mPhase = P_LOAD; mGame++;
    end else if (mPhase == P_LOAD) begin
      for (int i = 0; i < 16; i++) begin
        mFilled[i] = GIVEN[i];
        mBoard[i]  = GIVEN[i] ? keyCell(mGame, i / 4, i % 4) : 0;
      end
      mMistakes = 0;
      mPhase = P_PLAY;
    end else if (mPhase == P_PLAY && pl && !mFilled[r*4+c]) begin
      if (v == keyCell(mGame, r, c)) begin
        mBoard[r*4+c] = v;
        mFilled[r*4+c] = 1;
        nFilled = 0;
        for (int i = 0; i < 16; i++) nFilled += int'(mFilled[i]);
        if (nFilled == 16) mPhase = P_WON;
      end else begin
        mMistakes++;
        mWrong = 1;
        if (mMistakes >= MAXM) mPhase = P_LOST;
      end
    end
  endtask

  function automatic snap_t snapshot();
    snap_t s;
    for (int i = 0; i < 16; i++) begin
      s.board[i/4][i%4] = 2'(mBoard[i]);
      s.filled[i] = mFilled[i];
    end
    s.mistakes = 2'(mMistakes);
    s.wrong = mWrong;
    s.win   = (mPhase == P_WON);
    s.lose  = (mPhase == P_LOST);
    return s;
  endfunction

  // Drive one cycle of stimulus, predict the post-edge outputs, then settle.
  task automatic drive(input bit rst, input bit ng, input bit pl,
                       input int r, input int c, input int v);
    @(negedge clk);
    reset = rst; newGame = ng; place = pl;
    row = 2'(r); col = 2'(c); value = 2'(v);
    modelStep(rst, ng, pl, r, c, v);
    expQ.push_back(snapshot());
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, $urandom_range(3), $urandom_range(3), $urandom_range(3));
  endtask

  // Monitor: outputs are registered, so every edge presents a new response.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("board",    64'(board),    64'(e.board));
        check("filled",   64'(filled),   64'(e.filled));
        check("mistakes", 64'(mistakes), 64'(e.mistakes));
        check("wrong",    64'(wrong),    64'(e.wrong));
        check("win",      64'(win),      64'(e.win));
        check("lose",     64'(lose),     64'(e.lose));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, c, v;
    // Reset and game-0 givens.
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle();
    idle();
    check("rst_b00", 64'(board[0][0]), 64'd0);
    check("rst_b03", 64'(board[0][3]), 64'd1);
    check("rst_b11", 64'(board[1][1]), 64'd1);
    check("rst_filled", 64'(filled), 64'h9669);
    check("rst_winlose", 64'({win, lose}), 64'd0);

    // Correct placement, then a placement on the now-filled cell.
    drive(0, 0, 1, 0, 1, 3);
    check("p01_board", 64'(board[0][1]), 64'd3);
    check("p01_filled", 64'(filled), 64'h966B);
    check("p01_wrong", 64'(wrong), 64'd0);
    drive(0, 0, 1, 0, 1, 0);
    check("refill_board", 64'(board[0][1]), 64'd3);
    check("refill_wrong", 64'(wrong), 64'd0);

    // Three back-to-back wrong placements end the game.
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 1, 0, 2, 1);
      check("bad_wrong", 64'(wrong), 64'd1);
      check("bad_mistakes", 64'(mistakes), 64'(k));
    end
    check("bad_lose", 64'(lose), 64'd1);
    drive(0, 0, 1, 0, 2, 2);
    check("lose_hold_filled", 64'(filled), 64'h966B);
    check("lose_hold_wrong", 64'(wrong), 64'd0);

    // Full solve of game 0 after a reset.
    drive(1, 0, 0, 0, 0, 0);
    idle();
    drive(0, 0, 1, 0, 1, 3); drive(0, 0, 1, 0, 2, 2);
    drive(0, 0, 1, 1, 0, 2); drive(0, 0, 1, 1, 3, 3);
    drive(0, 0, 1, 2, 0, 1); drive(0, 0, 1, 2, 3, 0);
    drive(0, 0, 1, 3, 1, 0);
    check("prewin_win", 64'(win), 64'd0);
    drive(0, 0, 1, 3, 2, 1);
    check("win_filled", 64'(filled), 64'hFFFF);
    check("win_win", 64'(win), 64'd1);
    check("win_mistakes", 64'(mistakes), 64'd0);

    // newGame wins over a same-cycle place; game-1 givens load next.
    drive(0, 1, 1, 0, 1, 3);
    check("ng_filled", 64'(filled), 64'd0);
    check("ng_b01", 64'(board[0][1]), 64'd0);
    check("ng_win", 64'(win), 64'd0);
    idle();
    check("g1_b00", 64'(board[0][0]), 64'd1);
    check("g1_b03", 64'(board[0][3]), 64'd2);
    check("g1_filled", 64'(filled), 64'h9669);

    // Reset mid-play after two mistakes and three correct placements.
    drive(0, 0, 1, 0, 1, 0); drive(0, 0, 1, 0, 2, 1);
    drive(0, 0, 1, 0, 1, 3); drive(0, 0, 1, 0, 2, 0); drive(0, 0, 1, 1, 0, 0);
    check("mid_mistakes", 64'(mistakes), 64'd2);
    drive(1, 0, 1, 1, 3, 1);
    check("mr_board", 64'(board), 64'd0);
    check("mr_filled", 64'(filled), 64'd0);
    check("mr_status", 64'({mistakes, wrong, win, lose}), 64'd0);
    idle();
    check("mr_b03", 64'(board[0][3]), 64'd1);
    check("mr_filled2", 64'(filled), 64'h9669);

    // Randomized play; mostly correct values so games reach WIN as well as LOSE.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(3);
      c = $urandom_range(3);
      v = ($urandom_range(99) < 85) ? keyCell(mGame, r, c) : int'($urandom_range(3));
      drive($urandom_range(299) == 0, $urandom_range(79) == 0,
            $urandom_range(99) < 60, r, c, v);
    end

    idle();
    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
